// File: rtl/instruction_queue.sv
// Fetch-to-decode instruction FIFO with synchronous flush and registered occupancy count.
// Optional IQ_STALL_COUNT_EN adds a saturating StallCount of cycles where fetch was refused.
module instruction_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       In_Valid,
   output logic                       In_Ready,
   input  logic [DATA_W-1:0]          In_Instruction,
   input  logic [DATA_W-1:0]          In_PCPlus4,
   input  logic                       Flush,
   output logic                       Out_Valid,
   input  logic                       Out_Ready,
   output logic [DATA_W-1:0]          Out_Instruction,
   output logic [DATA_W-1:0]          Out_PCPlus4,
`ifdef IQ_STALL_COUNT_EN
   output logic [31:0]                StallCount,
`endif
   output logic [$clog2(DEPTH):0]     Count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [2*DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // Flush suppresses the pointer/count effect of a handshake but not the handshake signals themselves.
   assign push = In_Valid && !full && !Flush;
   assign pop  = !empty && Out_Ready && !Flush;

   assign In_Ready        = !full;
   assign Out_Valid       = !empty;
   assign Out_Instruction = empty ? '0 : mem[rd_ptr][2*DATA_W-1:DATA_W];
   assign Out_PCPlus4     = empty ? '0 : mem[rd_ptr][DATA_W-1:0];
   assign Count           = count;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (Flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= {In_Instruction, In_PCPlus4};
   end

`ifdef IQ_STALL_COUNT_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         StallCount <= '0;
      end else if (In_Valid && full && !Flush && (StallCount != 32'hFFFF_FFFF)) begin
         StallCount <= StallCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboard bench for instruction_queue: expected entries queued on accepted pushes, compared at the head.
module tb_instruction_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;

   logic                    Clk;
   logic                    Reset;
   logic                    In_Valid;
   logic                    In_Ready;
   logic [DATA_W-1:0]       In_Instruction;
   logic [DATA_W-1:0]       In_PCPlus4;
   logic                    Flush;
   logic                    Out_Valid;
   logic                    Out_Ready;
   logic [DATA_W-1:0]       Out_Instruction;
   logic [DATA_W-1:0]       Out_PCPlus4;
   logic [$clog2(DEPTH):0]  Count;
`ifdef IQ_STALL_COUNT_EN
   logic [31:0]             StallCount;
`endif

   instruction_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .In_Valid        (In_Valid),
      .In_Ready        (In_Ready),
      .In_Instruction  (In_Instruction),
      .In_PCPlus4      (In_PCPlus4),
      .Flush           (Flush),
      .Out_Valid       (Out_Valid),
      .Out_Ready       (Out_Ready),
      .Out_Instruction (Out_Instruction),
      .Out_PCPlus4     (Out_PCPlus4),
`ifdef IQ_STALL_COUNT_EN
      .StallCount      (StallCount),
`endif
      .Count           (Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;
   int pushes = 0;
   int pops   = 0;
   logic [63:0] sb [$];
   logic [31:0] exp_stall = '0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Compare every observable output against the model before the next edge.
   task automatic check_state(input string tag);
      check({tag, "_count"}, 64'(Count), 64'(sb.size()));
      check({tag, "_in_ready"}, 64'(In_Ready), 64'(sb.size() < DEPTH));
      check({tag, "_out_valid"}, 64'(Out_Valid), 64'(sb.size() != 0));
      if (sb.size() == 0)
         check({tag, "_empty_data"}, {Out_Instruction, Out_PCPlus4}, 64'd0);
      else
         check({tag, "_head"}, {Out_Instruction, Out_PCPlus4}, sb[0]);
`ifdef IQ_STALL_COUNT_EN
      check({tag, "_stall"}, 64'(StallCount), 64'(exp_stall));
`endif
   endtask

   // One clock: check, update model from the driven inputs, advance past the edge.
   task automatic step(input string tag);
      bit acc_push;
      bit acc_pop;
      check_state(tag);
      acc_push = In_Valid && (sb.size() < DEPTH) && !Flush;
      acc_pop  = Out_Ready && (sb.size() != 0) && !Flush;
      if (In_Valid && (sb.size() == DEPTH) && !Flush && exp_stall != 32'hFFFF_FFFF)
         exp_stall++;
      if (Flush) sb.delete();
      if (acc_pop) begin
         void'(sb.pop_front());
         pops++;
      end
      if (acc_push) begin
         sb.push_back({In_Instruction, In_PCPlus4});
         pushes++;
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [31:0] instr, input logic [31:0] pc, input bit rdy);
      In_Valid       = v;
      In_Instruction = instr;
      In_PCPlus4     = pc;
      Out_Ready      = rdy;
   endtask

   initial begin
      int n;
      int guard;
      Reset = 1'b0;
      Flush = 1'b0;
      drive(1'b0, '0, '0, 1'b0);

      // Reset held two cycles, released between edges.
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b1;
      #1;
      check_state("reset");
      @(posedge Clk);
      #1;

      // Fill to DEPTH, then a refused fifth push.
      for (int i = 1; i <= DEPTH; i++) begin
         drive(1'b1, 32'h2008_0000 + 32'(i), 32'(4 * i), 1'b0);
         step("fill");
      end
      check("full_count", 64'(Count), 64'(DEPTH));
      check("full_in_ready", 64'(In_Ready), 64'd0);
      drive(1'b1, 32'h2008_0005, 32'd20, 1'b0);
      step("refused");
      check("refused_count", 64'(Count), 64'(DEPTH));

      // Drain with continuing pushes until 10 pushed, wrapping the pointers twice.
      n = 5;
      guard = 0;
      while (pushes < 10 && guard < 50) begin
         drive(1'b1, 32'h2008_0000 + 32'(n), 32'(4 * n), 1'b1);
         if (sb.size() < DEPTH) n++;
         step("wrap");
         guard++;
      end
      guard = 0;
      drive(1'b0, '0, '0, 1'b1);
      while (sb.size() != 0 && guard < 20) begin
         step("drain");
         guard++;
      end
      check("wrap_guard", 64'(guard < 20), 64'd1);
      check("wrap_pushes", 64'(pushes), 64'd10);
      check("wrap_pops", 64'(pops), 64'd10);
      check("drained_count", 64'(Count), 64'd0);
      check("drained_valid", 64'(Out_Valid), 64'd0);

      // Simultaneous push and pop at occupancy 2.
      drive(1'b1, 32'hA000_0001, 32'h100, 1'b0); step("sim_a");
      drive(1'b1, 32'hA000_0002, 32'h104, 1'b0); step("sim_b");
      drive(1'b1, 32'hA000_0003, 32'h108, 1'b1); step("sim_pp");
      check("sim_count", 64'(Count), 64'd2);
      check("sim_head", 64'(Out_Instruction), 64'hA000_0002);

      // Flush at occupancy 3 with a push and pop requested in the same cycle.
      drive(1'b1, 32'hA000_0004, 32'h10C, 1'b0); step("pre_flush");
      check("pre_flush_count", 64'(Count), 64'd3);
      drive(1'b1, 32'hBAD0_BAD0, 32'h200, 1'b1);
      Flush = 1'b1;
      step("flush");
      Flush = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      check("flush_count", 64'(Count), 64'd0);
      check("flush_valid", 64'(Out_Valid), 64'd0);
      check("flush_data", {Out_Instruction, Out_PCPlus4}, 64'd0);
      drive(1'b1, 32'hC000_0001, 32'h300, 1'b0); step("post_flush");
      drive(1'b0, '0, '0, 1'b0);
      check("post_flush_head", 64'(Out_Instruction), 64'hC000_0001);
      step("post_flush_idle");

      // Asynchronous reset between edges at occupancy 2.
      drive(1'b1, 32'hD000_0002, 32'h304, 1'b0); step("pre_rst");
      drive(1'b0, '0, '0, 1'b0);
      check("pre_rst_count", 64'(Count), 64'd2);
      #2;
      Reset = 1'b0;
      #1;
      sb.delete();
      exp_stall = '0;
      check("async_count", 64'(Count), 64'd0);
      check("async_valid", 64'(Out_Valid), 64'd0);
      check("async_ready", 64'(In_Ready), 64'd1);
      #3;
      Reset = 1'b1;
      @(posedge Clk);
      #1;

      // Fill, then three cycles of refused fetch.
      for (int i = 1; i <= DEPTH + 3; i++) begin
         drive(1'b1, 32'hE000_0000 + 32'(i), 32'(8 * i), 1'b0);
         step("stall");
      end
      drive(1'b0, '0, '0, 1'b0);
      check_state("stall_end");
`ifdef IQ_STALL_COUNT_EN
      check("stall_count", 64'(StallCount), 64'd3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
